// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage with the multiply/divide unit.
package execute_pkg;

  // Execute control bus field positions
  localparam int EB_MF_HI  = 4;   // MF source: 1 = HI, 0 = LO
  localparam int EB_IMM    = 6;   // operand B = sign-extended immediate
  localparam int EB_SHAMT  = 7;   // operand A = shift amount
  localparam int EB_DST_RD = 8;   // destination = rd
  localparam int EB_DST_31 = 9;   // destination = r31
  localparam int EB_LINK   = 10;  // A = pc, B = 1
  localparam int EB_MD_LSB = 11;
  localparam int EB_MD_MSB = 12;

  // ALU operation encodings (execute_bus[3:0])
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Multiply/divide operation field
  typedef enum logic [1:0] {
    MD_NONE  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_MF    = 2'b11
  } mdop_e;

  // Iterative unit state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_e;

  // Operand source after forwarding
  typedef enum logic [1:0] {
    FW_REG = 2'd0,
    FW_MEM = 2'd1,
    FW_WB  = 2'd2
  } fw_sel_e;

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with HI/LO.
// One iteration per cycle; HI/LO are only written on the final iteration.
module muldiv_unit
  import execute_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic           busy,
  output logic [LEN-1:0] hi,
  output logic [LEN-1:0] lo
);

  localparam int CW = $clog2(LEN) + 1;

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0] acc_q, acc_d;    // partial product high half / remainder
  logic [LEN-1:0] quo_q, quo_d;    // multiplier being consumed / quotient
  logic [LEN-1:0] m_q, m_d;        // multiplicand / divisor
  logic [LEN-1:0] hi_q, hi_d;
  logic [LEN-1:0] lo_q, lo_d;

  logic [LEN:0]   mul_sum, div_sh, div_diff;
  logic           div_ok;
  logic [LEN-1:0] step_hi, step_lo;

  // One iteration of whichever operation is running
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, m_q} : '0);
    div_sh   = {acc_q, quo_q[LEN-1]};
    div_diff = div_sh - {1'b0, m_q};
    div_ok   = (div_sh >= {1'b0, m_q});
    if (state_q == S_MUL) begin
      step_hi = mul_sum[LEN:1];
      step_lo = {mul_sum[0], quo_q[LEN-1:1]};
    end else begin
      // divisor 0: every step succeeds, giving LO = all ones, HI = A
      step_hi = div_ok ? div_diff[LEN-1:0] : div_sh[LEN-1:0];
      step_lo = {quo_q[LEN-2:0], div_ok};
    end
  end

  // Next-state: latch operands on start, iterate, commit HI/LO on last step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = CW'(LEN);
          acc_d = '0;
          if (op == MD_DIVU) begin
            state_d = S_DIV;
            quo_d   = a;
            m_d     = b;
          end else begin
            state_d = S_MUL;
            quo_d   = b;
            m_d     = a;
          end
        end
      end
      default: begin
        acc_d = step_hi;
        quo_d = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = step_hi;
          lo_d    = step_lo;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/execute_muldiv.sv
// MIPS execute stage: forwarding, ALU, iterative MULTU/DIVU with HI/LO,
// stall request and flush, registered into EX/MEM.
module execute_muldiv
  import execute_pkg::*;
#(
  parameter int len          = 32,
  parameter int NB           = $clog2(len),
  parameter int len_exec_bus = 13,
  parameter int len_mem_bus  = 9,
  parameter int len_wb_bus   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [len-1:0]          in_pc_branch,
  input  logic [len-1:0]          in_reg1,
  input  logic [len-1:0]          in_reg2,
  input  logic [len-1:0]          in_sign_extend,
  input  logic [NB-1:0]           in_rs,
  input  logic [NB-1:0]           in_rt,
  input  logic [NB-1:0]           in_rd,
  input  logic [NB-1:0]           in_shamt,
  input  logic [len_exec_bus-1:0] execute_bus,
  input  logic [len_mem_bus-1:0]  memory_bus,
  input  logic [len_wb_bus-1:0]   writeBack_bus,
  input  logic                    register_write_3_4,
  input  logic                    register_write_4_5,
  input  logic [NB-1:0]           rd_3_4,
  input  logic [NB-1:0]           rd_4_5,
  input  logic [len-1:0]          in_mem_forw,
  input  logic [len-1:0]          in_wb_forw,
  input  logic                    flush,
  output logic                    stall_out,
  output logic [len-1:0]          out_pc_branch,
  output logic [len-1:0]          out_alu,
  output logic [len-1:0]          out_reg2,
  output logic [NB-1:0]           out_write_reg,
  output logic                    zero_flag,
  output logic [len_mem_bus-1:0]  memory_bus_out,
  output logic [len_wb_bus-1:0]   writeBack_bus_out
);

  fw_sel_e        sel_a, sel_b;
  logic [len-1:0] fwd_a, fwd_b, op_a, op_b, alu_res, result;
  logic [NB-1:0]  dest;
  logic [1:0]     mdop;
  logic           md_busy, md_start, bubble;
  logic [len-1:0] md_hi, md_lo;
  logic           unused_bits;

  logic [len-1:0]         pcb_q, pcb_d, alu_q, alu_d, reg2_q, reg2_d;
  logic [NB-1:0]          wreg_q, wreg_d;
  logic                   zero_q, zero_d;
  logic [len_mem_bus-1:0] mem_q, mem_d;
  logic [len_wb_bus-1:0]  wb_q, wb_d;

  assign mdop        = execute_bus[EB_MD_MSB:EB_MD_LSB];
  assign unused_bits = execute_bus[5];

  // Forwarding select: EX/MEM wins over MEM/WB, r0 is never forwarded
  always_comb begin
    sel_a = FW_REG;
    sel_b = FW_REG;
    if (register_write_3_4 && rd_3_4 != '0 && rd_3_4 == in_rs)      sel_a = FW_MEM;
    else if (register_write_4_5 && rd_4_5 != '0 && rd_4_5 == in_rs) sel_a = FW_WB;
    if (register_write_3_4 && rd_3_4 != '0 && rd_3_4 == in_rt)      sel_b = FW_MEM;
    else if (register_write_4_5 && rd_4_5 != '0 && rd_4_5 == in_rt) sel_b = FW_WB;
  end

  // Forwarding muxes and ALU operand selection
  always_comb begin
    case (sel_a)
      FW_MEM:  fwd_a = in_mem_forw;
      FW_WB:   fwd_a = in_wb_forw;
      default: fwd_a = in_reg1;
    endcase
    case (sel_b)
      FW_MEM:  fwd_b = in_mem_forw;
      FW_WB:   fwd_b = in_wb_forw;
      default: fwd_b = in_reg2;
    endcase
    if (execute_bus[EB_LINK])       op_a = in_pc_branch;
    else if (execute_bus[EB_SHAMT]) op_a = {{(len-NB){1'b0}}, in_shamt};
    else                            op_a = fwd_a;
    if (execute_bus[EB_LINK])       op_b = len'(1);
    else if (execute_bus[EB_IMM])   op_b = in_sign_extend;
    else                            op_b = fwd_b;
  end

  // ALU; shifts move operand B by the low bits of operand A
  always_comb begin
    case (execute_bus[3:0])
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:  alu_res = {{(len-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(len-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_res = op_b << op_a[NB-1:0];
      ALU_SRL:  alu_res = op_b >> op_a[NB-1:0];
      ALU_SRA:  alu_res = $signed(op_b) >>> op_a[NB-1:0];
      ALU_LUI:  alu_res = {op_b[len/2-1:0], {(len/2){1'b0}}};
      default:  alu_res = op_a + op_b;
    endcase
  end

  // Stall any mul/div-class op while the unit is busy; start only from idle
  assign stall_out = md_busy && (mdop != MD_NONE);
  assign md_start  = (mdop == MD_MULTU || mdop == MD_DIVU) && !md_busy && !flush;
  assign bubble    = stall_out || flush;

  muldiv_unit #(.LEN(len)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (mdop),
    .a     (fwd_a),
    .b     (fwd_b),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // EX/MEM next values; a bubble clears destination and control buses
  always_comb begin
    result = (mdop == MD_MF) ? (execute_bus[EB_MF_HI] ? md_hi : md_lo) : alu_res;
    if (execute_bus[EB_DST_31])      dest = NB'(31);
    else if (execute_bus[EB_DST_RD]) dest = in_rd;
    else                             dest = in_rt;
    pcb_d  = in_pc_branch + in_sign_extend;
    alu_d  = result;
    zero_d = (result == '0);
    reg2_d = fwd_b;
    wreg_d = bubble ? '0 : dest;
    mem_d  = bubble ? '0 : memory_bus;
    wb_d   = bubble ? '0 : writeBack_bus;
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcb_q  <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
      reg2_q <= '0;
      wreg_q <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
    end else begin
      pcb_q  <= pcb_d;
      alu_q  <= alu_d;
      zero_q <= zero_d;
      reg2_q <= reg2_d;
      wreg_q <= wreg_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
    end
  end

  assign out_pc_branch     = pcb_q;
  assign out_alu           = alu_q;
  assign zero_flag         = zero_q;
  assign out_reg2          = reg2_q;
  assign out_write_reg     = wreg_q;
  assign memory_bus_out    = mem_q;
  assign writeBack_bus_out = wb_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: driver pushes one expectation per
// cycle; monitor checks stall_out for that cycle and EX/MEM outputs a cycle later.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_pc_branch = '0, in_reg1 = '0, in_reg2 = '0, in_sign_extend = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [12:0] execute_bus = '0;
  logic [8:0]  memory_bus = '0;
  logic [1:0]  writeBack_bus = '0;
  logic        register_write_3_4 = 1'b0, register_write_4_5 = 1'b0;
  logic [4:0]  rd_3_4 = '0, rd_4_5 = '0;
  logic [31:0] in_mem_forw = '0, in_wb_forw = '0;
  logic        flush = 1'b0;
  logic        stall_out, zero_flag;
  logic [31:0] out_pc_branch, out_alu, out_reg2;
  logic [4:0]  out_write_reg;
  logic [8:0]  memory_bus_out;
  logic [1:0]  writeBack_bus_out;

  execute_muldiv dut (
    .clk(clk), .reset(reset),
    .in_pc_branch(in_pc_branch), .in_reg1(in_reg1), .in_reg2(in_reg2),
    .in_sign_extend(in_sign_extend),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .execute_bus(execute_bus), .memory_bus(memory_bus), .writeBack_bus(writeBack_bus),
    .register_write_3_4(register_write_3_4), .register_write_4_5(register_write_4_5),
    .rd_3_4(rd_3_4), .rd_4_5(rd_4_5), .in_mem_forw(in_mem_forw), .in_wb_forw(in_wb_forw),
    .flush(flush), .stall_out(stall_out),
    .out_pc_branch(out_pc_branch), .out_alu(out_alu), .out_reg2(out_reg2),
    .out_write_reg(out_write_reg), .zero_flag(zero_flag),
    .memory_bus_out(memory_bus_out), .writeBack_bus_out(writeBack_bus_out)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] ADD = 13'h000, SUB = 13'h001, OR = 13'h003, SLT = 13'h006,
                          SLTU = 13'h007, SLL = 13'h008, SRA = 13'h00A;
  localparam logic [12:0] IMM = 13'h040, SHAMT = 13'h080, DRD = 13'h100, D31 = 13'h200,
                          LINK = 13'h400;
  localparam logic [12:0] MULTU = 13'h0800, DIVU = 13'h1000, MFLO = 13'h1800, MFHI = 13'h1810;

  typedef struct {
    logic        stall;
    logic        chk;
    logic        chk_alu;
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  wreg;
    logic [8:0]  mem;
    logic [1:0]  wb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // forwarding settings applied together with the next issued instruction
  logic        fw_rw34 = 0, fw_rw45 = 0;
  logic [4:0]  fw_rd34 = 0, fw_rd45 = 0;
  logic [31:0] fw_mem = 0, fw_wb = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [12:0] eb, input logic [4:0] rs, rt, rd, sh,
                       input logic [31:0] r1, r2, imm, input logic [8:0] mem,
                       input logic [1:0] wb, input logic fl, input logic e_stall,
                       input logic chk_alu, input logic [31:0] e_alu, input logic [4:0] e_wreg);
    exp_t  e;
    logic  bub;
    @(posedge clk);
    #1;
    execute_bus = eb; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_reg1 = r1; in_reg2 = r2; in_sign_extend = imm; in_pc_branch = 32'h100;
    memory_bus = mem; writeBack_bus = wb; flush = fl;
    register_write_3_4 = fw_rw34; register_write_4_5 = fw_rw45;
    rd_3_4 = fw_rd34; rd_4_5 = fw_rd45; in_mem_forw = fw_mem; in_wb_forw = fw_wb;
    bub       = e_stall | fl;
    e.stall   = e_stall;
    e.chk     = 1'b1;
    e.chk_alu = chk_alu & ~bub;
    e.alu     = e_alu;
    e.zero    = (e_alu == 32'h0);
    e.wreg    = bub ? 5'd0 : e_wreg;
    e.mem     = bub ? 9'd0 : mem;
    e.wb      = bub ? 2'd0 : wb;
    sb.push_back(e);
  endtask

  task automatic alu_op(input logic [12:0] eb, input logic [4:0] rs, rt, rd, sh,
                        input logic [31:0] r1, r2, imm, input logic [8:0] mem,
                        input logic [1:0] wb, input logic fl,
                        input logic [31:0] e_alu, input logic [4:0] e_wreg);
    issue(eb, rs, rt, rd, sh, r1, r2, imm, mem, wb, fl, 1'b0, 1'b1, e_alu, e_wreg);
  endtask

  // MULTU/DIVU from idle: rs=1, rt=2, no write-back, destination field = rt
  task automatic md(input logic [12:0] eb, input logic [31:0] a, b, input logic e_stall);
    issue(eb, 5'd1, 5'd2, 5'd0, 5'd0, a, b, 32'h0, 9'h0, 2'b00, 1'b0, e_stall, 1'b0, 32'h0, 5'd2);
  endtask

  // MF to rd=8; waits out nst stalled cycles first
  task automatic mf(input logic [12:0] eb, input int nst, input logic [31:0] e_alu);
    for (int i = 0; i < nst; i++)
      issue(eb | DRD, 5'd0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 9'h011, 2'b01, 1'b0, 1'b1, 1'b0, 0, 5'd8);
    issue(eb | DRD, 5'd0, 5'd0, 5'd8, 5'd0, 0, 0, 0, 9'h011, 2'b01, 1'b0, 1'b0, 1'b1, e_alu, 5'd8);
  endtask

  // Monitor: stall_out of the newest record, EX/MEM outputs of the previous one
  initial begin
    exp_t r, prev;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        cmp("stall_out", {31'b0, stall_out}, {31'b0, r.stall});
        if (have && prev.chk) begin
          cmp("writeBack_bus_out", {30'b0, writeBack_bus_out}, {30'b0, prev.wb});
          cmp("memory_bus_out", {23'b0, memory_bus_out}, {23'b0, prev.mem});
          cmp("out_write_reg", {27'b0, out_write_reg}, {27'b0, prev.wreg});
          if (prev.chk_alu) begin
            cmp("out_alu", out_alu, prev.alu);
            cmp("zero_flag", {31'b0, zero_flag}, {31'b0, prev.zero});
          end
        end
        prev = r;
        have = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t tail;
    // reset state
    #3;
    cmp("rst_out_alu", out_alu, 32'h0);
    cmp("rst_pc_branch", out_pc_branch, 32'h0);
    cmp("rst_wb", {30'b0, writeBack_bus_out}, 32'h0);
    cmp("rst_mem", {23'b0, memory_bus_out}, 32'h0);
    cmp("rst_wreg", {27'b0, out_write_reg}, 32'h0);
    cmp("rst_zero", {31'b0, zero_flag}, 32'h0);
    cmp("rst_stall", {31'b0, stall_out}, 32'h0);
    #9 reset = 1'b1;

    // ALU path
    alu_op(ADD | DRD, 1, 2, 3, 0, 5, 7, 0, 9'h000, 2'b01, 0, 32'd12, 5'd3);
    alu_op(SUB | DRD, 1, 2, 4, 0, 9, 9, 0, 9'h1A3, 2'b10, 0, 32'd0, 5'd4);
    alu_op(OR | IMM, 1, 2, 0, 0, 32'hF0, 0, 32'h0F, 9'h000, 2'b01, 0, 32'hFF, 5'd2);
    alu_op(SLL | SHAMT | DRD, 1, 2, 5, 4, 32'hDEAD, 3, 0, 9'h000, 2'b01, 0, 32'h30, 5'd5);
    alu_op(ADD | LINK | D31, 1, 2, 0, 0, 7, 7, 0, 9'h000, 2'b01, 0, 32'h101, 5'd31);
    alu_op(SLT | DRD, 1, 2, 6, 0, 32'hFFFF_FFFF, 1, 0, 9'h000, 2'b01, 0, 32'd1, 5'd6);
    alu_op(SLTU | DRD, 1, 2, 6, 0, 32'hFFFF_FFFF, 1, 0, 9'h000, 2'b01, 0, 32'd0, 5'd6);
    alu_op(SRA | SHAMT | DRD, 1, 2, 7, 4, 0, 32'h8000_0000, 0, 9'h000, 2'b01, 0, 32'hF800_0000, 5'd7);

    // forwarding
    fw_rw34 = 1; fw_rw45 = 1; fw_rd34 = 5; fw_rd45 = 5; fw_mem = 100; fw_wb = 200;
    alu_op(ADD | DRD, 5, 6, 7, 0, 7, 3, 0, 9'h000, 2'b01, 0, 32'd103, 5'd7);
    fw_rd34 = 0;
    alu_op(ADD | DRD, 5, 6, 7, 0, 7, 3, 0, 9'h000, 2'b01, 0, 32'd203, 5'd7);
    fw_rd45 = 0;
    alu_op(ADD | DRD, 0, 6, 7, 0, 7, 3, 0, 9'h000, 2'b01, 0, 32'd10, 5'd7);
    fw_rd34 = 5; fw_rd45 = 5;
    alu_op(ADD | DRD, 1, 5, 7, 0, 7, 3, 0, 9'h000, 2'b01, 0, 32'd107, 5'd7);
    fw_rw34 = 0;
    alu_op(ADD | DRD, 1, 5, 7, 0, 7, 3, 0, 9'h000, 2'b01, 0, 32'd207, 5'd7);
    fw_rw45 = 0; fw_rd34 = 0; fw_rd45 = 0;

    // flush turns an ADD into a bubble
    alu_op(ADD | DRD, 1, 2, 3, 0, 5, 7, 0, 9'h055, 2'b01, 1, 32'd12, 5'd3);

    // MULTU 0x10000 * 0x10000, MFHI right behind it stalls 32 cycles
    md(MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    mf(MFHI, 32, 32'h1);
    mf(MFLO, 0, 32'h0);

    // DIVU 100 / 7
    md(DIVU, 32'd100, 32'd7, 1'b0);
    mf(MFLO, 32, 32'd14);
    mf(MFHI, 0, 32'd2);

    // DIVU 5 / 0
    md(DIVU, 32'd5, 32'd0, 1'b0);
    mf(MFHI, 32, 32'd5);
    mf(MFLO, 0, 32'hFFFF_FFFF);

    // back-to-back: DIVU waits out MULTU 3*5, then 20/6
    md(MULTU, 32'd3, 32'd5, 1'b0);
    for (int i = 0; i < 32; i++) md(DIVU, 32'd20, 32'd6, 1'b1);
    md(DIVU, 32'd20, 32'd6, 1'b0);
    mf(MFLO, 32, 32'd3);
    mf(MFHI, 0, 32'd2);

    // a flushed MULTU in idle must not start
    issue(MULTU, 1, 2, 0, 0, 7, 7, 0, 9'h0, 2'b00, 1'b1, 1'b0, 1'b0, 0, 5'd2);
    mf(MFLO, 0, 32'd3);

    // reset at busy cycle 10 aborts, HI/LO back to 0
    md(MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    for (int i = 0; i < 10; i++)
      issue(MFHI | DRD, 0, 0, 8, 0, 0, 0, 0, 9'h011, 2'b01, 1'b0, 1'b1, 1'b0, 0, 5'd8);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    cmp("midrst_out_alu", out_alu, 32'h0);
    cmp("midrst_wb", {30'b0, writeBack_bus_out}, 32'h0);
    cmp("midrst_wreg", {27'b0, out_write_reg}, 32'h0);
    cmp("midrst_stall", {31'b0, stall_out}, 32'h0);
    mf(MFHI, 0, 32'h0);
    #2 reset = 1'b1;
    mf(MFLO, 0, 32'h0);

    // tail record so the last expectation gets compared
    @(posedge clk);
    #1;
    execute_bus = '0; memory_bus = '0; writeBack_bus = '0; flush = 0;
    tail = '{stall: 1'b0, chk: 1'b0, chk_alu: 1'b0, alu: 32'h0, zero: 1'b0,
             wreg: 5'd0, mem: 9'd0, wb: 2'd0};
    sb.push_back(tail);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
